// File: rtl/instr_fetch_sequencer_if.sv
// ============================================================================
// Module   : instr_fetch_sequencer_if
// Purpose  : Bundle of program-memory and core-facing signals for the fetch
//            sequencer. The Step input exists only when FETCH_SINGLE_STEP_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  Enable;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [15:0]           MemData;
    logic [15:0]           DIN;
    logic                  Run;
    logic                  Done;
    logic [ADDR_WIDTH-1:0] PC;
    logic [15:0]           ContaInstrucao;
    logic                  Halted;
    logic                  Busy;
`ifdef FETCH_SINGLE_STEP_EN
    logic                  Step;

    modport master (
        input  Enable, MemData, Done, Step,
        output MemAddr, DIN, Run, PC, ContaInstrucao, Halted, Busy
    );
    modport slave (
        output Enable, MemData, Done, Step,
        input  MemAddr, DIN, Run, PC, ContaInstrucao, Halted, Busy
    );
`else
    modport master (
        input  Enable, MemData, Done,
        output MemAddr, DIN, Run, PC, ContaInstrucao, Halted, Busy
    );
    modport slave (
        output Enable, MemData, Done,
        input  MemAddr, DIN, Run, PC, ContaInstrucao, Halted, Busy
    );
`endif
endinterface

`default_nettype wire

// File: rtl/instr_fetch_sequencer.sv
// ============================================================================
// Module   : instr_fetch_sequencer
// Purpose  : Fetches opwords (plus the mvi immediate) from a synchronous-read
//            program memory, strobes them to the core and advances the PC on
//            Done. Optional single-step gate: FETCH_SINGLE_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_sequencer #(
    parameter int          ADDR_WIDTH = 5,
    parameter int          PROG_DEPTH = 32,
    parameter logic [3:0]  OPC_MVI    = 4'b0001,
    parameter logic [15:0] HALT_WORD  = 16'hFFFF
) (
    input  wire logic               Clock,
    input  wire logic               Resetn,
    instr_fetch_sequencer_if.master bus
);

    localparam logic [ADDR_WIDTH:0] c_prog_depth = (ADDR_WIDTH+1)'(PROG_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH_OP  = 4'd1,
        S_LATCH_OP  = 4'd2,
        S_FETCH_IMM = 4'd3,
        S_LATCH_IMM = 4'd4,
        S_ISSUE     = 4'd5,
        S_WAIT_DONE = 4'd6,
        S_HALT      = 4'd7
`ifdef FETCH_SINGLE_STEP_EN
        ,S_STEP_WAIT = 4'd8
`endif
    } state_t;

`ifdef FETCH_SINGLE_STEP_EN
    localparam state_t c_after_latch = S_STEP_WAIT;
`else
    localparam state_t c_after_latch = S_ISSUE;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] memaddr_q, memaddr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           din_q, din_d;
    logic [15:0]           opword_q, opword_d;
    logic [15:0]           imm_q, imm_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  is_mvi_q, is_mvi_d;
    logic                  run_q, run_d;
    logic                  halted_q, halted_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] pc_next;

`ifdef FETCH_SINGLE_STEP_EN
    logic step_q;
    logic step_rise;
    assign step_rise = bus.Step & ~step_q;
`endif

    // Addition modulo PROG_DEPTH; increments never exceed 2 so one subtract suffices.
    function automatic logic [ADDR_WIDTH-1:0] pc_add(input logic [ADDR_WIDTH-1:0] pc,
                                                     input logic [1:0]            inc);
        logic [ADDR_WIDTH:0] sum;
        sum = {1'b0, pc} + {{(ADDR_WIDTH-1){1'b0}}, inc};
        if (sum >= c_prog_depth) begin
            sum = sum - c_prog_depth;
        end
        return sum[ADDR_WIDTH-1:0];
    endfunction

    assign pc_next = pc_add(pc_q, is_mvi_q ? 2'd2 : 2'd1);

    always_comb begin
        state_d   = state_q;
        memaddr_d = memaddr_q;
        pc_d      = pc_q;
        din_d     = din_q;
        opword_d  = opword_q;
        imm_d     = imm_q;
        cnt_d     = cnt_q;
        is_mvi_d  = is_mvi_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Enable) begin
                    memaddr_d = pc_q;
                    state_d   = S_FETCH_OP;
                end
            end
            S_FETCH_OP:  state_d = S_LATCH_OP;
            S_LATCH_OP: begin
                opword_d = bus.MemData;
                if (bus.MemData == HALT_WORD) begin
                    state_d = S_HALT;
                end else if (bus.MemData[9:6] == OPC_MVI) begin
                    is_mvi_d  = 1'b1;
                    memaddr_d = pc_add(pc_q, 2'd1);
                    state_d   = S_FETCH_IMM;
                end else begin
                    is_mvi_d = 1'b0;
                    din_d    = bus.MemData;
                    state_d  = c_after_latch;
                end
            end
            S_FETCH_IMM: state_d = S_LATCH_IMM;
            S_LATCH_IMM: begin
                imm_d   = bus.MemData;
                din_d   = opword_q;
                state_d = c_after_latch;
            end
`ifdef FETCH_SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (step_rise) begin
                    state_d = S_ISSUE;
                end
            end
`endif
            S_ISSUE: begin
                // DIN switches to the immediate as soon as the opword strobe ends.
                din_d   = is_mvi_q ? imm_q : opword_q;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.Done) begin
                    pc_d  = pc_next;
                    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    if (bus.Enable) begin
                        memaddr_d = pc_next;
                        state_d   = S_FETCH_OP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        run_d    = (state_d == S_ISSUE);
        halted_d = (state_d == S_HALT);
        busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            memaddr_q <= '0;
            pc_q      <= '0;
            din_q     <= '0;
            opword_q  <= '0;
            imm_q     <= '0;
            cnt_q     <= '0;
            is_mvi_q  <= 1'b0;
            run_q     <= 1'b0;
            halted_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
            step_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            memaddr_q <= memaddr_d;
            pc_q      <= pc_d;
            din_q     <= din_d;
            opword_q  <= opword_d;
            imm_q     <= imm_d;
            cnt_q     <= cnt_d;
            is_mvi_q  <= is_mvi_d;
            run_q     <= run_d;
            halted_q  <= halted_d;
            busy_q    <= busy_d;
`ifdef FETCH_SINGLE_STEP_EN
            step_q    <= bus.Step;
`endif
        end
    end

    assign bus.MemAddr        = memaddr_q;
    assign bus.DIN            = din_q;
    assign bus.Run            = run_q;
    assign bus.PC             = pc_q;
    assign bus.ContaInstrucao = cnt_q;
    assign bus.Halted         = halted_q;
    assign bus.Busy           = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_sequencer.sv
// ============================================================================
// Module   : tb_instr_fetch_sequencer
// Purpose  : Scoreboard bench: a program-level model predicts the executed
//            instruction stream; a negedge monitor compares the DUT against it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_sequencer;

    typedef struct {
        bit          halt;
        bit          mvi;
        logic [15:0] op;
        logic [15:0] imm;
        logic [4:0]  pc;
        logic [4:0]  pc_after;
        logic [15:0] cnt_after;
    } exp_t;

    logic        Clock;
    logic        Resetn;
    logic [15:0] mem [32];
    exp_t        exp_q [$];
    int          n_checks;
    int          n_errors;
    bit          mon_active;
    logic [4:0]  model_pc;
    logic [15:0] model_cnt;

    instr_fetch_sequencer_if #(.ADDR_WIDTH(5)) bus ();

    instr_fetch_sequencer #(
        .ADDR_WIDTH(5),
        .PROG_DEPTH(32),
        .OPC_MVI   (4'b0001),
        .HALT_WORD (16'hFFFF)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous-read program memory
    always @(posedge Clock) bus.MemData <= mem[bus.MemAddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Program-level reference: walk the program as the core would see it.
    function automatic void build_model(input int n);
        int          pc;
        int          cnt;
        exp_t        r;
        logic [15:0] w;
        pc = 0;
        cnt = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            w = mem[pc];
            r = '{default: 0};
            r.pc = 5'(pc);
            if (w == 16'hFFFF) begin
                r.halt = 1'b1;
                r.pc_after = 5'(pc);
                r.cnt_after = 16'(cnt);
                exp_q.push_back(r);
                break;
            end
            r.op  = w;
            r.mvi = (w[9:6] == 4'b0001);
            r.imm = r.mvi ? mem[(pc + 1) % 32] : 16'h0000;
            pc  = (pc + (r.mvi ? 2 : 1)) % 32;
            cnt = cnt + 1;
            r.pc_after  = 5'(pc);
            r.cnt_after = 16'(cnt);
            exp_q.push_back(r);
        end
        model_pc  = 5'(pc);
        model_cnt = 16'(cnt);
    endfunction

    function automatic logic [15:0] rand_word(input bit mvi);
        logic [15:0] w;
        w = 16'($urandom);
        if (mvi) begin
            w[9:6] = 4'b0001;
        end else begin
            if (w[9:6] == 4'b0001) w[7] = 1'b1;
            if (w == 16'hFFFF) w[0] = 1'b0;
        end
        return w;
    endfunction

    // ---------------------------------------------------------------- monitor
    exp_t        cur;
    bit          have_cur;
    bit          after_run;
    bit          prev_busy;
    bit          prev_halted;
    logic [15:0] prev_cnt;
    int          cyc;
    int          start_cyc;

    always @(negedge Clock) begin
        exp_t h;
        cyc++;
        if (!mon_active) begin
            have_cur    = 1'b0;
            after_run   = 1'b0;
            prev_busy   = 1'b0;
            prev_halted = 1'b0;
            prev_cnt    = 16'h0000;
        end else begin
            if (after_run) begin
                check("din_wait", 32'(bus.DIN), 32'(cur.mvi ? cur.imm : cur.op));
                after_run = 1'b0;
            end
            if (bus.Busy && (!prev_busy || bus.ContaInstrucao != prev_cnt)) begin
                if (exp_q.size() == 0) fail("fetch_unexpected");
                else check("fetch_addr", 32'(bus.MemAddr), 32'(exp_q[0].pc));
                start_cyc = cyc;
            end
            if (bus.ContaInstrucao != prev_cnt) begin
                if (!have_cur) fail("count_without_instr");
                else begin
                    check("count", 32'(bus.ContaInstrucao), 32'(cur.cnt_after));
                    check("pc", 32'(bus.PC), 32'(cur.pc_after));
                end
                have_cur = 1'b0;
            end
            if (bus.Run) begin
                if (exp_q.size() == 0) fail("run_unexpected");
                else begin
                    cur = exp_q.pop_front();
                    have_cur  = 1'b1;
                    after_run = 1'b1;
                    check("run_not_halt", 32'(cur.halt), 32'(0));
                    check("din_op", 32'(bus.DIN), 32'(cur.op));
                    check("latency", 32'(cyc - start_cyc), 32'(cur.mvi ? 4 : 2));
                end
            end
            if (bus.Halted && !prev_halted) begin
                if (exp_q.size() == 0) fail("halt_unexpected");
                else begin
                    h = exp_q.pop_front();
                    check("halt_expected", 32'(h.halt), 32'(1));
                    check("halt_pc", 32'(bus.PC), 32'(h.pc));
                    check("halt_busy", 32'(bus.Busy), 32'(0));
                end
            end
            prev_busy   = bus.Busy;
            prev_halted = bus.Halted;
            prev_cnt    = bus.ContaInstrucao;
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic do_reset();
        mon_active = 1'b0;
        bus.Enable = 1'b0;
        bus.Done   = 1'b0;
        Resetn     = 1'b0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        check("rst_memaddr", 32'(bus.MemAddr), 32'(0));
        check("rst_din", 32'(bus.DIN), 32'(0));
        check("rst_pc", 32'(bus.PC), 32'(0));
        check("rst_count", 32'(bus.ContaInstrucao), 32'(0));
        check("rst_run", 32'(bus.Run), 32'(0));
        check("rst_halted", 32'(bus.Halted), 32'(0));
        check("rst_busy", 32'(bus.Busy), 32'(0));
        mon_active = 1'b1;
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clock);
            if (bus.Run) begin
                ok = 1'b1;
                return;
            end
        end
        fail("run_timeout");
    endtask

    // mode 0: finish idle; mode 1: expect a halt afterwards; mode 2: reset in last WAIT_DONE
    task automatic run_instrs(input int n, input int mode, input logic [4:0] halt_pc);
        bit          ok;
        bit          last;
        bit          got_halt;
        logic [4:0]  held_addr;
        bus.Enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_run(ok);
            if (!ok) return;
            last = (i == n - 1);
            if (mode == 2 && last) begin
                @(negedge Clock);
                check("pre_abort_count", 32'(bus.ContaInstrucao), 32'(n - 1));
                mon_active = 1'b0;
                #3 Resetn = 1'b0;
                #1;
                check("abort_run", 32'(bus.Run), 32'(0));
                check("abort_pc", 32'(bus.PC), 32'(0));
                check("abort_count", 32'(bus.ContaInstrucao), 32'(0));
                check("abort_din", 32'(bus.DIN), 32'(0));
                check("abort_busy", 32'(bus.Busy), 32'(0));
                return;
            end
            bus.Done = 1'($urandom % 2);
            @(negedge Clock);
            bus.Done = 1'b0;
            repeat ($urandom % 4) @(negedge Clock);
            bus.Enable = last ? (mode == 1) : ($urandom % 4 != 0);
            bus.Done = 1'b1;
            @(negedge Clock);
            bus.Done = 1'b0;
            if (!bus.Enable && !last) begin
                held_addr = bus.MemAddr;
                bus.Done = 1'b1;
                @(negedge Clock);
                bus.Done = 1'b0;
                repeat ($urandom % 3) @(negedge Clock);
                check("idle_busy", 32'(bus.Busy), 32'(0));
                check("idle_memaddr", 32'(bus.MemAddr), 32'(held_addr));
                bus.Enable = 1'b1;
            end
        end
        if (mode == 1) begin
            got_halt = 1'b0;
            for (int k = 0; k < 20 && !got_halt; k++) begin
                @(negedge Clock);
                got_halt = bus.Halted;
            end
            if (!got_halt) fail("halt_timeout");
            for (int k = 0; k < 6; k++) begin
                bus.Enable = ~bus.Enable;
                bus.Done   = 1'($urandom % 2);
                @(negedge Clock);
                check("halt_stay", 32'(bus.Halted), 32'(1));
                check("halt_run", 32'(bus.Run), 32'(0));
                check("halt_pc_hold", 32'(bus.PC), 32'(halt_pc));
            end
            bus.Done = 1'b0;
        end else if (mode == 0) begin
            held_addr = bus.MemAddr;
            repeat (5) @(negedge Clock);
            check("end_busy", 32'(bus.Busy), 32'(0));
            check("end_run", 32'(bus.Run), 32'(0));
            check("end_memaddr", 32'(bus.MemAddr), 32'(held_addr));
            check("end_pc", 32'(bus.PC), 32'(model_pc));
            check("end_count", 32'(bus.ContaInstrucao), 32'(model_cnt));
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        mon_active = 1'b0;
        cyc        = 0;
        start_cyc  = 0;
        Resetn     = 1'b0;
        bus.Enable = 1'b0;
        bus.Done   = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;

        // Single non-mvi instruction followed by halt
        mem[0] = 16'h0008;
        mem[1] = 16'hFFFF;
        do_reset();
        build_model(4);
        run_instrs(1, 1, 5'd1);

        // mvi with immediate, then halt at address 2
        mem[0] = 16'h0040;
        mem[1] = 16'h1234;
        mem[2] = 16'hFFFF;
        do_reset();
        build_model(4);
        run_instrs(1, 1, 5'd2);

        // 32 non-mvi words, PC wraps, random Enable drops and spurious Done
        for (int i = 0; i < 32; i++) mem[i] = rand_word(1'b0);
        do_reset();
        build_model(40);
        run_instrs(40, 0, 5'd0);

        // Mixed program; mvi at the last address takes its immediate from 0
        for (int i = 0; i < 32; i++) mem[i] = rand_word($urandom % 3 == 0);
        mem[30] = rand_word(1'b0);
        mem[31] = rand_word(1'b1);
        do_reset();
        build_model(60);
        run_instrs(60, 0, 5'd0);

        // Asynchronous reset while waiting for Done with count 5
        for (int i = 0; i < 32; i++) mem[i] = rand_word($urandom % 3 == 0);
        do_reset();
        build_model(6);
        run_instrs(6, 2, 5'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
